// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-number type and hazard control unit state encoding.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    // Hazard control unit states, kept as plain constants for legacy compatibility
    typedef logic [1:0] hcu_state_t;
    localparam hcu_state_t RUN      = 2'd0;
    localparam hcu_state_t MEM_WAIT = 2'd1;
    localparam hcu_state_t HALTED   = 2'd2;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard control unit bundle.
//   hcu: pipeline status inputs (ihit, dhit, EX/MEM, ID/EX, IF/ID, MEM/WB info);
//        drives stage enables, stage flushes, halted and the event counters.
//   tb : mirror view for the driving environment.
interface hazard_control_unit_if #(parameter int unsigned CNT_W = 16);
    import cpu_types_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             exm_dREN;
    logic             exm_dWEN;
    logic             exm_branch_taken;
    logic             idex_dREN;
    regbits_t         idex_rt_out;
    regbits_t         ifid_rs;
    regbits_t         ifid_rt;
    logic             mwb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exm_en;
    logic             mwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exm_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hcu (
        input  ihit, dhit, exm_dREN, exm_dWEN, exm_branch_taken,
               idex_dREN, idex_rt_out, ifid_rs, ifid_rt, mwb_halt,
        output pc_en, ifid_en, idex_en, exm_en, mwb_en,
               ifid_flush, idex_flush, exm_flush, halted, stall_cnt, flush_cnt
    );

    modport tb (
        output ihit, dhit, exm_dREN, exm_dWEN, exm_branch_taken,
               idex_dREN, idex_rt_out, ifid_rs, ifid_rt, mwb_halt,
        input  pc_en, ifid_en, idex_en, exm_en, mwb_en,
               ifid_flush, idex_flush, exm_flush, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
//   CLK, nRST : clock, synchronous active-low reset
//   inc       : count one event this cycle
//   count     : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stalls on data-memory wait and load-use,
// flushes on taken branches and instruction misses, stops on HALT.
//   CLK, nRST : clock, synchronous active-low reset
//   hif       : status inputs in, stage enables/flushes, halted, counters out
// Enables and flushes are combinational from state and inputs.
module hazard_control_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    hazard_control_unit_if.hcu    hif
);

    hcu_state_t state;
    hcu_state_t nextState;

    logic memwait;
    logic loaduse;
    logic pcEn, ifidEn, idexEn, exmEn, mwbEn;
    logic ifidFlush, idexFlush, exmFlush;
    logic haltedC;
    logic stallInc, flushInc;

    assign memwait = (hif.exm_dREN | hif.exm_dWEN) & ~hif.dhit;
    assign loaduse = hif.idex_dREN & (hif.idex_rt_out != '0) &
                     ((hif.idex_rt_out == hif.ifid_rs) | (hif.idex_rt_out == hif.ifid_rt));

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next state and pipeline control
    always_comb begin
        nextState = state;
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexEn    = 1'b0;
        exmEn     = 1'b0;
        mwbEn     = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        exmFlush  = 1'b0;
        haltedC   = 1'b0;
        stallInc  = 1'b0;
        flushInc  = 1'b0;

        if (!nRST) begin
            // Reset loads bubbles everywhere regardless of the current state
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            exmFlush  = 1'b1;
            nextState = RUN;
        end else if (state == HALTED) begin
            haltedC = 1'b1;
        end else if (hif.mwb_halt) begin
            nextState = HALTED;
        end else if ((state == RUN) && memwait) begin
            stallInc  = 1'b1;
            nextState = MEM_WAIT;
        end else if ((state == MEM_WAIT) && !hif.dhit) begin
            stallInc = 1'b1;
        end else begin
            // RUN decision; a completing MEM_WAIT lands here with memwait cleared by dhit
            nextState = RUN;
            if (hif.exm_branch_taken) begin
                {pcEn, ifidEn, idexEn, exmEn, mwbEn} = 5'b11111;
                {ifidFlush, idexFlush, exmFlush}     = 3'b111;
                flushInc = 1'b1;
            end else if (loaduse) begin
                // Hold PC and IF/ID, insert one bubble into ID/EX
                exmEn     = 1'b1;
                mwbEn     = 1'b1;
                idexFlush = 1'b1;
                stallInc  = 1'b1;
            end else if (!hif.ihit) begin
                {ifidEn, idexEn, exmEn, mwbEn} = 4'b1111;
                ifidFlush = 1'b1;
                stallInc  = 1'b1;
            end else begin
                {pcEn, ifidEn, idexEn, exmEn, mwbEn} = 5'b11111;
            end
        end
    end

    assign hif.pc_en      = pcEn;
    assign hif.ifid_en    = ifidEn;
    assign hif.idex_en    = idexEn;
    assign hif.exm_en     = exmEn;
    assign hif.mwb_en     = mwbEn;
    assign hif.ifid_flush = ifidFlush;
    assign hif.idex_flush = idexFlush;
    assign hif.exm_flush  = exmFlush;
    assign hif.halted     = haltedC;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stallInc),
        .count (hif.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flushInc),
        .count (hif.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with 4-bit counters.
module tb_hazard_control_unit;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic CLK;
    logic nRST;
    int   nAssert;
    int   nFail;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_control_unit #(.CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif.hcu)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [4:0] enV;
    logic [2:0] flV;
    assign enV = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exm_en, hif.mwb_en};
    assign flV = {hif.ifid_flush, hif.idex_flush, hif.exm_flush};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkCtl(input string tag, input logic [4:0] en, input logic [2:0] fl);
        chk({tag, "_en"}, 16'(enV), 16'(en));
        chk({tag, "_fl"}, 16'(flV), 16'(fl));
    endtask

    task automatic chkCnt(input string tag, input int st, input int fl);
        chk({tag, "_stall"}, 16'(hif.stall_cnt), 16'(st));
        chk({tag, "_flush"}, 16'(hif.flush_cnt), 16'(fl));
    endtask

    // Quiet pipeline: fetch hits, no memory op, no hazards
    task automatic idle();
        hif.ihit             = 1'b1;
        hif.dhit             = 1'b0;
        hif.exm_dREN         = 1'b0;
        hif.exm_dWEN         = 1'b0;
        hif.exm_branch_taken = 1'b0;
        hif.idex_dREN        = 1'b0;
        hif.idex_rt_out      = 5'd3;
        hif.ifid_rs          = 5'd1;
        hif.ifid_rt          = 5'd2;
        hif.mwb_halt         = 1'b0;
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nAssert = 0;
        nFail   = 0;
        nRST    = 1'b0;
        idle();
        #2;
        chkCtl("rst", 5'b00000, 3'b111);
        chk("rst_halted", 16'(hif.halted), 16'd0);
        cyc();
        chkCnt("rst", 0, 0);

        nRST = 1'b1;
        #1;
        chkCtl("normal", 5'b11111, 3'b000);
        cyc();
        chkCnt("normal", 0, 0);

        // Load-use through rs
        hif.idex_dREN = 1'b1; hif.idex_rt_out = 5'd5; hif.ifid_rs = 5'd5;
        #1;
        chk("lu_en", 16'({hif.pc_en, hif.ifid_en, hif.exm_en, hif.mwb_en}), 16'b0011);
        chk("lu_fl", 16'(flV), 16'b010);
        cyc();
        chkCnt("lu", 1, 0);
        idle();
        #1;
        chkCtl("lu_after", 5'b11111, 3'b000);
        cyc();
        chkCnt("lu_after", 1, 0);

        // $zero destination never stalls
        hif.idex_dREN = 1'b1; hif.idex_rt_out = 5'd0; hif.ifid_rs = 5'd0;
        #1;
        chkCtl("zero", 5'b11111, 3'b000);
        cyc();
        chkCnt("zero", 1, 0);

        // Load-use through rt
        hif.idex_dREN = 1'b1; hif.idex_rt_out = 5'd7; hif.ifid_rs = 5'd1; hif.ifid_rt = 5'd7;
        #1;
        chk("lurt_pc", 16'(hif.pc_en), 16'd0);
        chk("lurt_idexfl", 16'(hif.idex_flush), 16'd1);
        cyc();
        chkCnt("lurt", 2, 0);
        idle();

        // Memory wait: three cycles without dhit, then completion
        hif.exm_dREN = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chkCtl("mw_wait", 5'b00000, 3'b000);
            cyc();
        end
        chkCnt("mw_wait", 5, 0);
        hif.dhit = 1'b1;
        #1;
        chkCtl("mw_done", 5'b11111, 3'b000);
        cyc();
        chkCnt("mw_done", 5, 0);
        idle();
        #1;
        chkCtl("mw_run", 5'b11111, 3'b000);
        cyc();

        // Branch beats load-use
        hif.exm_branch_taken = 1'b1;
        hif.idex_dREN = 1'b1; hif.idex_rt_out = 5'd5; hif.ifid_rs = 5'd5;
        #1;
        chkCtl("br", 5'b11111, 3'b111);
        cyc();
        chkCnt("br", 5, 1);
        idle();

        // Instruction miss
        hif.ihit = 1'b0;
        #1;
        chkCtl("imiss", 5'b01111, 3'b100);
        cyc();
        chkCnt("imiss", 6, 1);
        idle();

        // Memwait beats branch; branch applied once dhit arrives from MEM_WAIT
        hif.exm_branch_taken = 1'b1; hif.exm_dWEN = 1'b1;
        #1;
        chkCtl("mwbr_wait", 5'b00000, 3'b000);
        cyc();
        chkCnt("mwbr_wait", 7, 1);
        hif.dhit = 1'b1;
        #1;
        chkCtl("mwbr_done", 5'b11111, 3'b111);
        cyc();
        chkCnt("mwbr_done", 7, 2);
        idle();

        // Halt wins over everything; HALTED freezes outputs and counters
        hif.mwb_halt = 1'b1; hif.exm_dREN = 1'b1; hif.exm_branch_taken = 1'b1;
        #1;
        chkCtl("halt_req", 5'b00000, 3'b000);
        cyc();
        chk("halt_state", 16'(hif.halted), 16'd1);
        chkCnt("halt_req", 7, 2);
        idle();
        hif.ihit = 1'b0; hif.exm_branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chkCtl("halted", 5'b00000, 3'b000);
            chk("halted_flag", 16'(hif.halted), 16'd1);
            cyc();
        end
        chkCnt("halted", 7, 2);

        // Reset out of HALTED
        nRST = 1'b0;
        #1;
        chkCtl("halt_rst", 5'b00000, 3'b111);
        chk("halt_rst_flag", 16'(hif.halted), 16'd0);
        cyc();
        chkCnt("halt_rst", 0, 0);
        idle();
        nRST = 1'b1;
        #1;
        chkCtl("halt_rel", 5'b11111, 3'b000);
        chk("halt_rel_flag", 16'(hif.halted), 16'd0);
        cyc();

        // Reset abandons MEM_WAIT
        hif.exm_dREN = 1'b1;
        cyc();
        chkCnt("mwrst_wait", 1, 0);
        nRST = 1'b0;
        #1;
        chkCtl("mwrst", 5'b00000, 3'b111);
        cyc();
        chkCnt("mwrst", 0, 0);
        nRST = 1'b1;
        idle();
        #1;
        chkCtl("mwrst_rel", 5'b11111, 3'b000);
        cyc();

        // Stall counter saturation
        hif.ihit = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        chkCnt("sat14", 14, 0);
        for (int i = 0; i < 6; i++) cyc();
        chkCnt("sat20", 15, 0);
        idle();
        cyc();
        chkCnt("sat_hold", 15, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of each performance counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 nRST  input  1  synchronous active-low reset.
REQ-005 ihit  input  1  instruction memory returned the fetch this cycle.
REQ-006 dhit  input  1  data memory completed the EX/MEM access this cycle.
REQ-007 exm_dREN, exm_dWEN  input  1 each  EX/MEM holds a load or store.
REQ-008 exm_branch_taken  input  1  branch or jump resolved taken in EX/MEM.
REQ-009 idex_dREN  input  1  ID/EX holds a load; idex_rt_out  input  regbits_t  its destination.
REQ-010 ifid_rs, ifid_rt  input  regbits_t  IF/ID source registers.
REQ-011 mwb_halt  input  1  HALT reached MEM/WB.
REQ-012 pc_en, ifid_en, idex_en, exm_en, mwb_en  output  1 each  pipeline register enables.
REQ-013 ifid_flush, idex_flush, exm_flush  output  1 each  load a bubble (NOP, all controls 0).
REQ-014 halted  output  1  processor stopped.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.
REQ-016 The ports are grouped in interface hazard_control_unit_if with modports hcu and tb.

Function
REQ-017 State machine with states RUN, MEM_WAIT and HALTED; state and counters are the only registers; all other outputs are combinational from state and inputs.
REQ-018 memwait = (exm_dREN|exm_dWEN) & ~dhit.
REQ-019 loaduse = idex_dREN & (idex_rt_out != 0) & (idex_rt_out == ifid_rs | idex_rt_out == ifid_rt).
REQ-020 Decision priority, highest first: mwb_halt, memwait, exm_branch_taken, loaduse, ~ihit, normal.
REQ-021 Halt: in any state, mwb_halt=1 forces all enables 0 and all flushes 0 that cycle; next state is HALTED.
REQ-022 Memwait in RUN: all enables 0 and all flushes 0; next state MEM_WAIT.
REQ-023 MEM_WAIT with dhit=0: all enables 0, no flush; state held.
REQ-024 MEM_WAIT with dhit=1: outputs equal the RUN decision with memwait=0; next state RUN; no extra idle cycle.
REQ-025 Branch taken: all enables 1, pc_en=1 (target load), ifid_flush=idex_flush=exm_flush=1; flush_cnt increments.
REQ-026 Load-use: pc_en=0, ifid_en=0, idex_flush=1, exm_en=mwb_en=1; exactly one bubble; no state change; re-evaluated next cycle.
REQ-027 ~ihit with no higher condition: pc_en=0, ifid_flush=1, all other enables 1.
REQ-028 Normal: all enables 1, all flushes 0.
REQ-029 A flush input overrides its stage enable; the register is cleared even when the enable is 0.
REQ-030 stall_cnt increments each cycle pc_en=0 while not HALTED and not halting.
REQ-031 Both counters saturate at all-ones; there is no wrap-around.
REQ-032 HALTED: halted=1, all enables 0, no flushes, counters frozen; exit only by reset.

Reset
REQ-033 While nRST=0 at a clock edge: next state RUN and both counters 0.
REQ-034 While nRST=0: all enables 0, all flushes 1 and halted=0, regardless of state.
REQ-035 A reset asserted during MEM_WAIT or HALTED abandons the state; normal decisions resume the first cycle after nRST rises.

Structure
REQ-036 hcu_state_t (RUN, MEM_WAIT, HALTED) is added to cpu_types_pkg alongside regbits_t.
REQ-037 A sub-module sat_counter (parameter W; inputs CLK, nRST, inc; output count) is instantiated twice.

Verification
REQ-038 Load-use: idex_dREN=1, idex_rt_out=5, ifid_rs=5, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-039 $zero: same as REQ-038 with idex_rt_out=0, ifid_rs=0 -> no stall; all enables 1.
REQ-040 Memory wait: exm_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all enables 0 in MEM_WAIT, then RUN with enables 1; stall_cnt=3.
REQ-041 Branch priority: exm_branch_taken=1 and loaduse true in the same cycle -> flush outputs only, pc_en=1; flush_cnt=1, stall_cnt unchanged.
REQ-042 Saturation: CNT_W=4, ihit=0 for 20 cycles -> stall_cnt=15 and held.
REQ-043 Halt and reset: mwb_halt=1 -> halted=1 next cycle; enables held 0 for 10 cycles; nRST=0 -> flushes 1; after release, state RUN and counters 0.
